// File: rtl/accel_host_driver.sv
// Host-side job sequencer for an array-based kernel. Loads a job into the
// kernel's control array from an input stream, kicks the kernel, waits
// (bounded) for completion, then drains the array back out as a stream.
module accel_host_driver #(
  parameter int AW      = 10,
  parameter int DW      = 64,
  parameter int DEPTH   = 1000,
  parameter int TIMEOUT = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        len,
  input  logic [AW-1:0]        init_i,
  input  logic signed [DW-1:0] init_acc,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 result,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic                 k_r_enable,
  output logic [AW-1:0]        k_init_i,
  output logic signed [DW-1:0] k_init_acc,
  output logic                 k_controlArr,
  output logic                 k_controlArrWEnable_a,
  output logic [AW-1:0]        k_controlArrAddr_a,
  output logic [DW-1:0]        k_controlArrWData_a,
  input  logic [DW-1:0]        k_controlArrRData_a,
  input  logic                 k_w_enable,
  input  logic                 k_result
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT, S_RADDR, S_RCAPT, S_ROUT, S_FIN
  } state_t;

  state_t               state;
  logic [AW-1:0]        cnt;
  logic [AW-1:0]        len_q;
  logic [AW-1:0]        init_i_q;
  logic signed [DW-1:0] init_acc_q;
  logic [TW-1:0]        tcnt;
  logic                 err_q;
  logic                 result_q;
  logic [DW-1:0]        rdata_q;
  logic [AW-1:0]        len_c;
  logic                 is_last;

  // Jobs longer than the kernel array are truncated to the array size.
  assign len_c   = (len > DEPTH_W) ? DEPTH_W : len;
  assign is_last = (cnt == len_q - AW'(1));

  // All status/kernel controls decode from registered state; only the write
  // strobe follows in_valid so the word is written in its handshake cycle.
  assign busy                  = (state != S_IDLE);
  assign done                  = (state == S_FIN);
  assign err                   = err_q;
  assign result                = result_q;
  assign in_ready              = (state == S_LOAD) && (cnt < len_q);
  assign out_valid             = (state == S_ROUT);
  assign out_data              = rdata_q;
  assign out_last              = (state == S_ROUT) && is_last;
  assign k_r_enable            = (state == S_KICK);
  assign k_init_i              = init_i_q;
  assign k_init_acc            = init_acc_q;
  assign k_controlArr          = (state == S_LOAD) || (state == S_RADDR) ||
                                 (state == S_RCAPT) || (state == S_ROUT);
  assign k_controlArrWEnable_a = in_ready && in_valid;
  assign k_controlArrAddr_a    = cnt;
  assign k_controlArrWData_a   = in_data;

  // Job sequencer: load -> kick -> bounded wait -> read/capture/emit per word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      init_i_q   <= '0;
      init_acc_q <= '0;
      tcnt       <= '0;
      err_q      <= 1'b0;
      result_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= len_c;
            init_i_q   <= init_i;
            init_acc_q <= init_acc;
            cnt        <= '0;
            err_q      <= 1'b0;
            result_q   <= 1'b0;
            state      <= (len_c == '0) ? S_KICK : S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_ready && in_valid) cnt <= cnt + AW'(1);
          if (cnt == len_q) state <= S_KICK;
        end
        S_KICK: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (k_w_enable) begin
            result_q <= k_result;
            cnt      <= '0;
            state    <= (len_q == '0) ? S_FIN : S_RADDR;
          end else if (tcnt == T_LAST) begin
            err_q <= 1'b1;
            state <= S_FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_RADDR: state <= S_RCAPT;
        S_RCAPT: begin
          // Array has one cycle of read latency from the RADDR address.
          rdata_q <= k_controlArrRData_a;
          state   <= S_ROUT;
        end
        S_ROUT: begin
          if (out_ready) begin
            cnt   <= cnt + AW'(1);
            state <= is_last ? S_FIN : S_RADDR;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_host_driver.sv
// Randomized scoreboard bench: a prefix-sum kernel model owns the array,
// job tasks push expected writes/words/completions, a negedge monitor pops
// and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_accel_host_driver;
  localparam int AW = 11, DW = 64, DEPTH = 1000, TIMEOUT = 16;

  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] len = '0, init_i = '0;
  logic signed [DW-1:0] init_acc = '0;
  logic busy, done, err, result;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b1, out_last;
  logic [DW-1:0] out_data;
  logic k_r_enable, k_controlArr, k_controlArrWEnable_a;
  logic [AW-1:0] k_init_i, k_controlArrAddr_a;
  logic signed [DW-1:0] k_init_acc;
  logic [DW-1:0] k_controlArrWData_a, k_controlArrRData_a;
  logic k_w_enable, k_result;

  always #5 clk = ~clk;

  accel_host_driver #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init_i(init_i), .init_acc(init_acc),
    .busy(busy), .done(done), .err(err), .result(result),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .k_r_enable(k_r_enable), .k_init_i(k_init_i), .k_init_acc(k_init_acc),
    .k_controlArr(k_controlArr), .k_controlArrWEnable_a(k_controlArrWEnable_a),
    .k_controlArrAddr_a(k_controlArrAddr_a), .k_controlArrWData_a(k_controlArrWData_a),
    .k_controlArrRData_a(k_controlArrRData_a), .k_w_enable(k_w_enable), .k_result(k_result));

  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name, input string why);
    checks++;
    $display("FAIL %s: %s", name, why);
  endtask

  // ---------------- kernel model: prefix sum from init_i with init_acc ----
  typedef logic [DW-1:0] mem_t [0:(1<<AW)-1];
  mem_t kmem;
  int kcount = -1, kii = 0, k_delay = 0;
  bit k_hang = 0, k_res_bit = 0;
  logic [DW-1:0] kacc = '0;

  function automatic mem_t kernel_run(input mem_t m, input int ii, input logic [DW-1:0] acc);
    mem_t r = m;
    logic [DW-1:0] s = acc;
    for (int i = ii; i < DEPTH; i++) begin
      s = s + m[i];
      r[i] = s;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcount <= -1; k_w_enable <= 1'b0; k_result <= 1'b0;
    end else begin
      k_w_enable <= 1'b0;
      k_controlArrRData_a <= kmem[k_controlArrAddr_a];
      if (k_r_enable) begin
        kcount <= k_hang ? -1 : k_delay;
        kii <= int'(k_init_i);
        kacc <= k_init_acc;
      end else if (kcount == 0) begin
        kmem <= kernel_run(kmem, kii, kacc);
        k_w_enable <= 1'b1;
        k_result <= k_res_bit;
        kcount <= -1;
      end else begin
        if (kcount > 0) kcount <= kcount - 1;
        if (k_controlArr && k_controlArrWEnable_a) kmem[k_controlArrAddr_a] <= k_controlArrWData_a;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [DW-1:0] d; logic last; } out_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic err; logic res; } dn_t;
  out_t out_q[$];
  wr_t  wr_q[$];
  dn_t  dn_q[$];
  logic [DW-1:0] job_data[$];

  int kicks = 0, dones = 0, drained = 0, stall_seen = 0, stall_left = 0, ready_mode = 0;
  longint cyc = 0, kick_cyc = 0, done_cyc = 0;
  logic [AW-1:0] exp_ii = '0;
  logic [DW-1:0] exp_acc = '0;
  bit held = 0;
  logic [DW-1:0] held_data;
  logic [AW-1:0] held_addr;
  out_t m_o; wr_t m_w; dn_t m_d;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: everything sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (k_controlArrWEnable_a) begin
        chk("wr_owns_array", k_controlArr, 1);
        if (wr_q.size() == 0) flag("wr_unexpected", $sformatf("write addr %0d with nothing expected", k_controlArrAddr_a));
        else begin
          m_w = wr_q.pop_front();
          chk("wr_addr", k_controlArrAddr_a, m_w.a);
          chk("wr_data", k_controlArrWData_a, m_w.d);
        end
      end
      if (k_r_enable) begin
        kicks++; kick_cyc = cyc;
        chk("kick_array_released", k_controlArr, 0);
        chk("kick_init_i", k_init_i, exp_ii);
        chk("kick_init_acc", k_init_acc, exp_acc);
      end
      if (out_valid) begin
        if (held) begin
          chk("hold_data", out_data, held_data);
          chk("hold_addr", k_controlArrAddr_a, held_addr);
        end
        if (out_ready) begin
          held = 0;
          if (out_q.size() == 0) flag("out_unexpected", $sformatf("word %0h with nothing expected", out_data));
          else begin
            m_o = out_q.pop_front();
            chk("out_data", out_data, m_o.d);
            chk("out_last", out_last, m_o.last);
          end
          drained++;
        end else begin
          held = 1; held_data = out_data; held_addr = k_controlArrAddr_a;
          if (drained == 1) stall_seen++;
        end
      end else held = 0;
      if (done) begin
        dones++; done_cyc = cyc;
        if (dn_q.size() == 0) flag("done_unexpected", "done with no job outstanding");
        else begin
          m_d = dn_q.pop_front();
          chk("done_err", err, m_d.err);
          if (!m_d.err) chk("done_result", result, m_d.res);
        end
      end
    end
  end

  // out_ready driver: 0 always ready, 1 random, 2 stall word 1 for stall_left cycles
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: if (out_valid && drained == 1 && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
         else out_ready = 1'b1;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic stream(input int n, input bit gaps);
    bit hs; int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1; in_data = job_data[i]; t = 0;
      do begin @(negedge clk); hs = in_ready; @(posedge clk); #1; t++; end while (!hs && t < 100);
      if (!hs) flag("load_stall", $sformatf("word %0d not accepted within 100 cycles", i));
    end
    in_valid = 1'b0;
  endtask

  task automatic issue_start(input int n_req, input int ii, input logic [DW-1:0] acc0);
    @(posedge clk); #1;
    chk("idle_before_start", busy, 0);
    start = 1'b1; len = AW'(n_req); init_i = AW'(ii); init_acc = acc0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_job(input int n_req, input int ii, input logic [DW-1:0] acc0,
                         input bit hang, input int rmode, input bit gaps, input bit poke);
    int n, t, k0, d0;
    logic [DW-1:0] run;
    out_t o; wr_t w; dn_t e;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    run = acc0;
    for (int i = 0; i < n; i++) begin
      w.a = AW'(i); w.d = job_data[i]; wr_q.push_back(w);
      if (!hang) begin
        if (i >= ii) run = run + job_data[i];
        o.d = (i >= ii) ? run : job_data[i];
        o.last = (i == n - 1);
        out_q.push_back(o);
      end
    end
    e.err = hang; e.res = 1'($urandom_range(0, 1)); dn_q.push_back(e);
    k_hang = hang; k_delay = $urandom_range(0, 10); k_res_bit = e.res;
    ready_mode = rmode; stall_left = (rmode == 2) ? 5 : 0; stall_seen = 0;
    drained = 0; held = 0;
    exp_ii = AW'(ii); exp_acc = acc0; k0 = kicks; d0 = dones;
    issue_start(n_req, ii, acc0);
    stream(n, gaps);
    if (poke) begin
      chk("busy_at_poke", busy, 1);
      start = 1'b1; len = AW'(7); init_i = '0; init_acc = ~acc0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (dones == d0 && t < 20000) begin @(posedge clk); t++; end
    if (dones == d0) flag("done_timeout", "no done within 20000 cycles");
    #1;
    chk("idle_after_done", busy, 0);
    chk("kick_pulses", kicks - k0, 1);
    chk("words_drained", drained, hang ? 0 : n);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("out_q_empty", out_q.size(), 0);
    if (hang) chk("timeout_cycles", done_cyc - kick_cyc, TIMEOUT + 1);
    if (rmode == 2) chk("stall_cycles", stall_seen, 5);
    wr_q.delete(); out_q.delete(); dn_q.delete();
  endtask

  task automatic fill_random(input int n);
    job_data.delete();
    for (int i = 0; i < n; i++) job_data.push_back({$urandom, $urandom});
  endtask

  initial begin
    int k0, n, ii;
    // power-on reset
    #2 rst_n = 1'b0; #1;
    chk("reset_outputs", {busy, done, err, result, in_ready, out_valid, out_last,
                          k_r_enable, k_controlArr, k_controlArrWEnable_a}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // prefix sum of 1,2,3,4
    job_data = {64'd1, 64'd2, 64'd3, 64'd4};
    run_job(4, 0, '0, 0, 0, 0, 0);
    // empty job
    run_job(0, 0, 64'd5, 0, 0, 0, 0);
    // consumer stall on word 1
    fill_random(3);
    run_job(3, 0, {$urandom, $urandom}, 0, 2, 0, 0);
    // kernel never completes
    fill_random(3);
    run_job(3, 0, '0, 1, 0, 0, 0);

    // reset during load: two of four words written
    job_data = {64'd11, 64'd12, 64'd13, 64'd14};
    for (int i = 0; i < 2; i++) begin m_w.a = AW'(i); m_w.d = job_data[i]; wr_q.push_back(m_w); end
    exp_ii = '0; exp_acc = '0; k_hang = 0;
    issue_start(4, 0, '0);
    stream(2, 0);
    k0 = kicks;
    in_valid = 1'b1; in_data = job_data[2];
    #1 rst_n = 1'b0; #1;
    chk("midjob_reset_outputs", {busy, done, err, result, in_ready, out_valid, out_last,
                                 k_r_enable, k_controlArr, k_controlArrWEnable_a}, 0);
    chk("midjob_writes_done", wr_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0; rst_n = 1'b1;
    chk("midjob_no_kick", kicks - k0, 0);
    wr_q.delete(); out_q.delete(); dn_q.delete();
    fill_random(2);
    run_job(2, 0, {$urandom, $urandom}, 0, 1, 1, 0);

    // start while busy is ignored
    fill_random(6);
    run_job(6, 1, {$urandom, $urandom}, 0, 1, 1, 1);
    // oversized length clamps to the array size
    fill_random(DEPTH);
    run_job(2000, 0, {$urandom, $urandom}, 0, 0, 0, 0);

    // random jobs
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(0, 12);
      ii = (n == 0) ? 0 : $urandom_range(0, n);
      fill_random(n);
      run_job(n, ii, {$urandom, $urandom}, 0, 1, 1, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
